div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multicycle signed 32-bit divider that produces the HI/LO pair for DIV: HI = remainder, LO = quotient.
- Sits beside the multiplier, upstream of the HI/LO select muxes and the HI/LO registers.
- Started by a one-cycle pulse from the control unit; reports completion with `done` and divide-by-zero with `div_zero`.
- The `div_zero` flag feeds the control unit's exception path.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (register A output).
- divisor  input  WIDTH  signed divisor (register B output).
- busy  output  1  high while a division is in progress (RUN or FIX).
- done  output  1  one-cycle pulse when `hi`/`lo` carry a new result.
- div_zero  output  1  one-cycle pulse when start is sampled with divisor == 0.
- hi  output  WIDTH  remainder of the last completed division.
- lo  output  WIDTH  quotient of the last completed division.

Behaviour:
- Reset (asynchronous, reset == 0):
  - state = IDLE.
  - busy, done, div_zero = 0.
  - hi, lo = 0; all internal registers cleared.
  - Applies at any moment, including mid-division. The aborted result is discarded and no `done` is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - start = 1 and divisor == 0 at edge E0:
    - div_zero <= 1 for exactly one cycle.
    - State stays IDLE; hi/lo unchanged; no done.
  - start = 1 and divisor != 0 at edge E0:
    - Latch the absolute values of dividend and divisor (unsigned WIDTH bits; |0x80000000| = 0x80000000).
    - Latch sign_q = dividend[WIDTH-1] XOR divisor[WIDTH-1] and sign_r = dividend[WIDTH-1].
    - Clear the partial remainder (WIDTH+1 bits); iteration counter = WIDTH-1; state -> RUN.
- RUN (edges E1..E_WIDTH): one restoring step per edge.
  - Shift {rem, quotient} left by 1, bringing in the next dividend bit.
  - trial = rem - |divisor|. If trial >= 0: rem = trial and quotient bit = 1; otherwise rem is restored and quotient bit = 0.
  - Counter decrements; after the WIDTH-th step, state -> FIX.
- FIX (edge E_WIDTH+1):
  - lo <= sign_q ? -quotient : quotient.
  - hi <= sign_r ? -rem : rem.
  - done <= 1 for one cycle; state -> IDLE.
- Latency: done is visible in the cycle after edge E(WIDTH+1), i.e. 33 edges after the start edge for WIDTH = 32.
- A new start is accepted in the cycle where done = 1, because the state is already IDLE.
- busy = 1 in RUN and FIX, otherwise 0; busy is registered.
- start while busy: ignored; it neither restarts nor queues.
- Semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign (MIPS DIV).
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, no flag raised.
  - All arithmetic wraps modulo 2^WIDTH.
- hi and lo hold their values between completions and change only on the FIX edge or on reset.
- dividend and divisor may change freely after E0; they are not re-sampled.

Decomposition:
- Shared package `div_pkg`:
  - state enum (IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2);
  - WIDTH default;
  - counter width localparam, $clog2(WIDTH).
- One natural sub-module, `div_step`: purely combinational restoring iteration.
  - Inputs: rem, quotient, |divisor|.
  - Outputs: next rem, next quotient.
  - Instantiated once and used every RUN cycle.
- FSM, sign handling and output registers stay in `div_unit`.

Test Plan:
- 100 / 7, start pulse: busy high 33 cycles, then done pulse; lo = 14, hi = 2; div_zero stays 0.
- -7 / 2 (0xFFFFFFF9 / 0x2): lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). Then 7 / -2: lo = 0xFFFFFFFD, hi = 1.
- 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, done after 33 edges. Also 0 / 5: lo = 0, hi = 0.
- Preload hi = 2, lo = 14; start with 42 / 0: div_zero high exactly one cycle after the start edge, busy and done never assert, hi/lo remain 2/14.
- Start 1000 / 3, second start pulse at iteration 5 with 9 / 3: ignored; result lo = 333, hi = 1. Immediate restart on the done cycle with 9 / 3: lo = 3, hi = 0 after a further 33 edges.
- Start 1000 / 3, drive reset low asynchronously at iteration 10 (mid-cycle): busy, done, hi, lo drop to 0 immediately; no done after release. A fresh 20 / 6 then gives lo = 3, hi = 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider: FSM encoding,
// default operand width and iteration counter width.
package div_pkg;

   localparam int WIDTH_DEFAULT = 32;
   localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quotient} left by one,
// trial-subtract the divisor magnitude and keep the result only if it fits.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quotient,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quotient_next
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;
   logic             fits;

   always_comb begin
      shifted = {rem, quotient[WIDTH-1]};
      fits    = (shifted >= {2'b00, divisor});
      diff    = shifted[WIDTH:0] - {1'b0, divisor};
      if (fits) begin
         rem_next      = diff;
         quotient_next = {quotient[WIDTH-2:0], 1'b1};
      end else begin
         rem_next      = shifted[WIDTH:0];
         quotient_next = {quotient[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (MIPS DIV): hi = remainder, lo = quotient.
// Magnitudes are divided by restoring steps, signs are reapplied in FIX.
module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH:0]   rem, rem_next;
   logic [WIDTH-1:0] quo, quo_next;
   logic [WIDTH-1:0] dvs, dvs_next;
   logic             sign_q, sign_q_next;
   logic             sign_r, sign_r_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             busy_next, done_next, div_zero_next;
   logic [WIDTH-1:0] hi_next, lo_next;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;

   // Two's-complement magnitude; the most negative value maps onto itself,
   // which is exactly its unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem           (rem),
      .quotient      (quo),
      .divisor       (dvs),
      .rem_next      (step_rem),
      .quotient_next (step_quo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state    <= state_next;
         rem      <= rem_next;
         quo      <= quo_next;
         dvs      <= dvs_next;
         sign_q   <= sign_q_next;
         sign_r   <= sign_r_next;
         cnt      <= cnt_next;
         busy     <= busy_next;
         done     <= done_next;
         div_zero <= div_zero_next;
         hi       <= hi_next;
         lo       <= lo_next;
      end
   end

   always_comb begin
      state_next    = state;
      rem_next      = rem;
      quo_next      = quo;
      dvs_next      = dvs;
      sign_q_next   = sign_q;
      sign_r_next   = sign_r;
      cnt_next      = cnt;
      hi_next       = hi;
      lo_next       = lo;
      done_next     = 1'b0;
      div_zero_next = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  div_zero_next = 1'b1;
               end else begin
                  rem_next    = '0;
                  quo_next    = abs_val(dividend);
                  dvs_next    = abs_val(divisor);
                  sign_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sign_r_next = dividend[WIDTH-1];
                  cnt_next    = CNT_INIT;
                  state_next  = RUN;
               end
            end
         end
         RUN: begin
            rem_next = step_rem;
            quo_next = step_quo;
            if (cnt == '0) state_next = FIX;
            else           cnt_next   = cnt - CNT_W'(1);
         end
         FIX: begin
            // Quotient truncates toward zero, remainder follows the dividend.
            lo_next    = sign_q ? -quo : quo;
            hi_next    = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == RUN) || (state_next == FIX);
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // Reference model state: result becomes visible 33 edges after acceptance.
   logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_left = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r_hi, output logic [31:0] r_lo);
      longint sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      r_lo = q[31:0];
      r_hi = r[31:0];
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
         m_hi = '0; m_lo = '0; m_left = 0;
      end else begin
         m_done = 1'b0;
         m_dz = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_busy = 1'b0;
            end
         end else if (start) begin
            if (divisor == 32'd0) m_dz = 1'b1;
            else begin
               ref_div(dividend, divisor, p_hi, p_lo);
               m_left = 33;
               m_busy = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (busy !== m_busy || done !== m_done || div_zero !== m_dz || hi !== m_hi || lo !== m_lo) begin
            bad++;
            $display("FAIL model_cycle t=%0t busy/done/dz/hi/lo actual=%b/%b/%b/%h/%h required=%b/%b/%b/%h/%h",
                     $time, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the start edge.
   task automatic start_div(input logic [31:0] a, input logic [31:0] b);
      dividend = a;
      divisor = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output int bc);
      n = 0;
      bc = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL done_timeout actual=%0d cycles required=done pulse", n);
      end
   endtask

   task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_lo, input logic [31:0] e_hi);
      int n, bc;
      start_div(a, b);
      wait_done(n, bc);
      check({name, "_latency"}, n, 32'd33);
      check({name, "_busy_cycles"}, bc, 32'd33);
      check({name, "_lo"}, lo, e_lo);
      check({name, "_hi"}, hi, e_hi);
   endtask

   initial begin
      int n, bc, dc;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dz", {31'd0, div_zero}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);

      // Divide by zero: one-cycle flag, no activity, hi/lo held.
      start_div(32'd42, 32'd0);
      check("dz_pulse", {31'd0, div_zero}, 32'd1);
      check("dz_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("dz_drop", {31'd0, div_zero}, 32'd0);
      dc = 0;
      repeat (5) begin
         if (busy === 1'b1 || done === 1'b1) dc++;
         @(negedge clk);
      end
      check("dz_no_activity", dc, 32'd0);
      check("dz_hi_held", hi, 32'd2);
      check("dz_lo_held", lo, 32'd14);

      run_div("dm7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
      @(negedge clk);
      run_div("d7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
      @(negedge clk);
      run_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
      @(negedge clk);
      run_div("d0_5", 32'd0, 32'd5, 32'd0, 32'd0);
      @(negedge clk);

      // A start while busy is ignored.
      start_div(32'd1000, 32'd3);
      repeat (4) @(negedge clk);
      start_div(32'd9, 32'd3);
      wait_done(n, bc);
      check("ign_latency", n, 32'd28);
      check("ign_lo", lo, 32'd333);
      check("ign_hi", hi, 32'd1);
      // Restart on the done cycle.
      run_div("restart_9_3", 32'd9, 32'd3, 32'd3, 32'd0);
      @(negedge clk);

      // Asynchronous reset in the middle of a division.
      start_div(32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      dc = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dc++;
      end
      check("arst_no_done", dc, 32'd0);
      run_div("d20_6", 32'd20, 32'd6, 32'd3, 32'd2);
      @(negedge clk);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
